// File: rtl/pdm_mic_capture_ctrl.sv
// PDM microphone capture sequencer: generates mclk/lrsel, runs a warm-up,
// then decimates left/right bit streams by ones-counting into PCM samples.
module pdm_mic_capture_ctrl #(
    parameter int CLK_DIV  = 25,
    parameter int WIN      = 64,
    parameter int OUT_W    = 7,
    parameter int WARM_CYC = 2048
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             dataint,
    output logic             mclk,
    output logic             lrsel,
    output logic [OUT_W-1:0] pcm_l,
    output logic [OUT_W-1:0] pcm_r,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic             clr_ovr,
    output logic             overrun,
    output logic             busy
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int BIT_W = $clog2(WIN);
    localparam int WRM_W = $clog2(WARM_CYC + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIN - 1);
    localparam logic [WRM_W-1:0] WRM_LAST = WRM_W'(WARM_CYC - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WARMUP = 2'd1,
        RUN    = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [DIV_W-1:0]   div_cnt;
    logic [1:0]         sync;
    logic [1:0]         mode_q;
    logic [WRM_W-1:0]   warm_cnt;
    logic [BIT_W-1:0]   bitcnt;
    logic [OUT_W-1:0]   cnt_l, cnt_r;

    logic din_s, wrap, rise_evt, fall_evt, start;
    logic use_l, use_r, bit_l, bit_r;
    logic warm_done, win_close, xfer, accept, drop;
    logic [OUT_W-1:0] smp_r;

    assign din_s     = sync[1];
    assign wrap      = (state != IDLE) && (div_cnt == DIV_LAST);
    assign rise_evt  = wrap && !mclk;
    assign fall_evt  = wrap && mclk;
    assign start     = (state == IDLE) && en;

    // Mono modes zero the unused channel by masking its bits.
    assign use_l     = (mode_q != 2'd1);
    assign use_r     = (mode_q != 2'd0);
    assign bit_l     = use_l & din_s;
    assign bit_r     = use_r & din_s;

    assign warm_done = (state == WARMUP) && rise_evt && (warm_cnt == WRM_LAST);
    assign win_close = (state == RUN) && rise_evt && (bitcnt == BIT_LAST);
    // The closing rise carries the window's last right bit.
    assign smp_r     = cnt_r + OUT_W'(bit_r);

    assign xfer      = out_valid && out_ready;
    assign accept    = win_close && (!out_valid || out_ready);
    assign drop      = win_close && out_valid && !out_ready;

    assign busy      = (state != IDLE);
    assign lrsel     = (mode_q == 2'd1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (en) state_nxt = WARMUP;
            WARMUP: begin
                if (!en)           state_nxt = IDLE;
                else if (warm_done) state_nxt = RUN;
            end
            RUN:     if (win_close && !en) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Divider is parked in IDLE and on the cycle that enters IDLE, so mclk
    // drops together with busy and the first rise lands CLK_DIV after start.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt <= '0;
            mclk    <= 1'b0;
        end else if (state == IDLE || state_nxt == IDLE) begin
            div_cnt <= '0;
            mclk    <= 1'b0;
        end else if (wrap) begin
            div_cnt <= '0;
            mclk    <= ~mclk;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) sync <= '0;
        else        sync <= {sync[0], dataint};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)     mode_q <= '0;
        else if (start) mode_q <= (mode == 2'd3) ? 2'd2 : mode;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                            warm_cnt <= '0;
        else if (start)                        warm_cnt <= '0;
        else if (state == WARMUP && rise_evt)  warm_cnt <= warm_cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_l  <= '0;
            cnt_r  <= '0;
            bitcnt <= '0;
        end else if (start || warm_done || win_close) begin
            cnt_l  <= '0;
            cnt_r  <= '0;
            bitcnt <= '0;
        end else if (state == RUN) begin
            if (fall_evt) cnt_l <= cnt_l + OUT_W'(bit_l);
            if (rise_evt) begin
                cnt_r  <= cnt_r + OUT_W'(bit_r);
                bitcnt <= bitcnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pcm_l     <= '0;
            pcm_r     <= '0;
            out_valid <= 1'b0;
        end else if (accept) begin
            pcm_l     <= cnt_l;
            pcm_r     <= smp_r;
            out_valid <= 1'b1;
        end else if (xfer) begin
            out_valid <= 1'b0;
        end
    end

    // A drop wins over a same-cycle clear so no overrun is lost.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                overrun <= 1'b0;
        else if (drop)             overrun <= 1'b1;
        else if (clr_ovr || start) overrun <= 1'b0;
    end

endmodule
